serial_bus_arbiter: RTL and testbench
=====================================

Name: serial_bus_arbiter

Overview:
- Shared-bus arbiter and router between MASTERS serial bus masters and SLAVES serial slaves.
- Grants one master at a time using round-robin.
- Routes the granted master's serial lines (control, wD, valid, last) to the addressed slave, and routes that slave's rD/ready back.
- Holds the grant until the master signals transaction completion. Sits inside the bus interconnect, between master ports and slave ports.

Parameters:
- MASTERS, 2, number of requesting masters (>=2)
- SLAVES, 3, number of slaves on the bus
- SLAVEID, $clog2(SLAVES), width of a slave select field
- TIMEOUT, 1024, busy-cycle limit before forced release (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- req  in  MASTERS  per-master bus request, level, held for the whole transaction
- req_slave  in  MASTERS*SLAVEID  target slave index per master; master i uses slice [i*SLAVEID +: SLAVEID]
- done  in  MASTERS  one-cycle pulse from a master: its transaction is finished
- grant  out  MASTERS  one-hot grant, registered
- err  out  MASTERS  one-cycle pulse: request rejected because of an invalid slave index
- m_control, m_wD, m_valid, m_last  in  MASTERS each  serial lines from the masters
- m_rD, m_ready  out  MASTERS each  serial lines back to the masters
- s_control, s_wD, s_valid, s_last  out  SLAVES each  serial lines to the slaves
- s_rD, s_ready  in  SLAVES each  serial lines from the slaves

Behaviour:
- Reset values: grant=0, err=0, all s_* outputs 0, all m_* outputs 0, rr pointer=0 (master 0 highest priority), state IDLE.
- State machine:
  - IDLE: if any req is set, pick the winner by scanning from the rr pointer upward (wrapping).
    - Valid req_slave (<SLAVES): register grant one-hot, latch the slave index into sel_slave, go to BUSY.
    - Invalid req_slave: pulse err[winner] for one cycle, no grant, advance the pointer past the winner, stay IDLE.
  - BUSY: routing is active. Exit to RELEASE when done[granted]=1 OR req[granted]=0 (abort). In either case grant clears at the same edge and the pointer becomes winner+1 mod MASTERS. done from a non-granted master is ignored.
  - RELEASE: exactly one turnaround cycle with all routes idle; arbitration is performed here with IDLE's rules, so a waiting master is granted at the end of this cycle.
- Latency:
  - req sampled at edge k -> grant visible after edge k.
  - done sampled at edge k -> grant=0 after k; next grant after k+1.
- Routing is combinational from the registered grant/sel_slave:
  - s_*[sel_slave] = m_*[granted]; all other s_* = 0.
  - m_rD[granted] = s_rD[sel_slave] and m_ready[granted] = s_ready[sel_slave]; non-granted m_rD/m_ready = 0.
  - No routing in IDLE/RELEASE.
- req_slave is sampled only at grant; changes during BUSY are ignored.
- Simultaneous done and a new req from another master: RELEASE is taken first. There is never a zero-gap handover.
- Reset mid-transaction: every output returns to its reset value immediately (asynchronous) and the pointer returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: a busy counter ($clog2(TIMEOUT+1) bits) clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT without done or req drop, the arbiter forces RELEASE and pulses timeout_err[granted] (extra output, MASTERS wide, reset 0) for one cycle. The pointer advances as on a normal release.
- Undefined: no counter, no timeout_err port; BUSY persists until done or req drop.

Decomposition:
- Package serial_bus_pkg:
  - arbiter state enum (IDLE, BUSY, RELEASE)
  - idle line value constants
  - function onehot_to_idx
- Sub-module arb_rr_picker: combinational round-robin picker (inputs req vector and pointer; outputs one-hot winner and any_req).

Test Plan:
- Reset: hold resetn=0 -> grant=00, err=00, s_control=000, m_ready=00; release reset with req=00 -> outputs remain 0.
- Single request: req=01, req_slave[0]=2 at edge 0 -> grant=01 after edge 0; m_control[0] toggle pattern 1,1,1,0 appears on s_control[2] the same cycles; s_control[0], s_control[1]=0; s_ready[2]=0 seen on m_ready[0].
- Contention: req=11 from reset -> master 0 granted; done[0] pulse at edge 10 -> grant=00 for one cycle, grant=10 after edge 11.
- Fairness: repeated req=11 with immediate done -> grant sequence 01,10,01,10.
- Invalid slave: req=10, req_slave[1]=3 -> err=10 for exactly one cycle, grant stays 00.
- Abort and timeout: req[0] dropped at edge 5 of BUSY -> RELEASE. With ARB_TIMEOUT_EN and TIMEOUT=16: no done for 16 BUSY cycles -> grant=00 and timeout_err=01 for one cycle.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (busy-cycle timeout with forced release).
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Level driven onto any serial line that is not currently routed.
  localparam logic LINE_IDLE = 1'b0;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_if.sv
// Bus bundle between the masters, the slaves and the arbiter.
// Optional feature macro: ARB_TIMEOUT_EN adds the timeout_err pulse vector.
interface serial_bus_arbiter_if #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 3,
  parameter int SLAVEID = $clog2(SLAVES)
);
  logic [MASTERS-1:0]         req;
  logic [MASTERS*SLAVEID-1:0] req_slave;
  logic [MASTERS-1:0]         done;
  logic [MASTERS-1:0]         grant;
  logic [MASTERS-1:0]         err;
  logic [MASTERS-1:0]         m_control, m_wD, m_valid, m_last;
  logic [MASTERS-1:0]         m_rD, m_ready;
  logic [SLAVES-1:0]          s_control, s_wD, s_valid, s_last;
  logic [SLAVES-1:0]          s_rD, s_ready;
`ifdef ARB_TIMEOUT_EN
  logic [MASTERS-1:0]         timeout_err;

  // Environment side: masters and slaves drive requests and serial lines.
  modport master (
    output req, req_slave, done, m_control, m_wD, m_valid, m_last, s_rD, s_ready,
    input  grant, err, m_rD, m_ready, s_control, s_wD, s_valid, s_last, timeout_err
  );
  // Arbiter side.
  modport slave (
    input  req, req_slave, done, m_control, m_wD, m_valid, m_last, s_rD, s_ready,
    output grant, err, m_rD, m_ready, s_control, s_wD, s_valid, s_last, timeout_err
  );
`else
  // Environment side: masters and slaves drive requests and serial lines.
  modport master (
    output req, req_slave, done, m_control, m_wD, m_valid, m_last, s_rD, s_ready,
    input  grant, err, m_rD, m_ready, s_control, s_wD, s_valid, s_last
  );
  // Arbiter side.
  modport slave (
    input  req, req_slave, done, m_control, m_wD, m_valid, m_last, s_rD, s_ready,
    output grant, err, m_rD, m_ready, s_control, s_wD, s_valid, s_last
  );
`endif
endinterface

// File: rtl/serial_bus_arbiter_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module arb_rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any_req
);
  logic found;

  // Two passes: upper half [ptr..N-1] first, then the wrapped part [0..ptr-1].
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter/router between serial bus masters and slaves.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after TIMEOUT busy cycles).
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 3,
  parameter int SLAVEID = $clog2(SLAVES)
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic clk,
  input  logic resetn,
  serial_bus_arbiter_if.slave bus
);
  localparam int PTRW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  arb_state_e         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [MASTERS-1:0] err_q, err_d;
  logic [PTRW-1:0]    ptr_q, ptr_d;
  logic [SLAVEID-1:0] sel_q, sel_d;
`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [MASTERS-1:0] tout_q, tout_d;
`endif

  logic [MASTERS-1:0] win_oh;
  logic               any_req;
  int                 win_idx, gnt_idx;
  logic [SLAVEID-1:0] win_slave;
  logic               win_valid;
  logic               gnt_done, gnt_req;

  // Pointer value that puts the master after idx at highest priority.
  function automatic logic [PTRW-1:0] ptr_after(input int idx);
    return (idx >= MASTERS - 1) ? '0 : PTRW'(idx + 1);
  endfunction

  arb_rr_picker #(.N(MASTERS), .PW(PTRW)) u_picker (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (win_oh),
    .any_req (any_req)
  );

  assign win_idx   = onehot_to_idx(32'(win_oh));
  assign gnt_idx   = onehot_to_idx(32'(grant_q));
  assign win_slave = bus.req_slave[win_idx*SLAVEID +: SLAVEID];
  assign win_valid = int'(win_slave) < SLAVES;
  assign gnt_done  = |(bus.done & grant_q);
  assign gnt_req   = |(bus.req & grant_q);

  // Next-state logic: arbitrate in IDLE/RELEASE, watch for completion in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    err_d   = '0;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = '0;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (any_req) begin
          if (win_valid) begin
            grant_d = win_oh;
            sel_d   = win_slave;
            state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Reject the bad target and let the next master have a turn.
            err_d = win_oh;
            ptr_d = ptr_after(win_idx);
          end
        end
      end
      BUSY: begin
        if (gnt_done || !gnt_req) begin
          grant_d = '0;
          ptr_d   = ptr_after(gnt_idx);
          state_d = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          grant_d = '0;
          ptr_d   = ptr_after(gnt_idx);
          tout_d  = grant_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      err_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.err   = err_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = tout_q;
`endif

  // Routing: only the selected slave and the granted master see live lines.
  logic               route_active;
  logic [SLAVES-1:0]  sel_oh;
  logic               m_control_g, m_wd_g, m_valid_g, m_last_g;
  logic               s_rd_g, s_ready_g;

  assign route_active = (state_q == BUSY);
  assign m_control_g  = |(bus.m_control & grant_q);
  assign m_wd_g       = |(bus.m_wD & grant_q);
  assign m_valid_g    = |(bus.m_valid & grant_q);
  assign m_last_g     = |(bus.m_last & grant_q);
  assign s_rd_g       = |(bus.s_rD & sel_oh);
  assign s_ready_g    = |(bus.s_ready & sel_oh);

  for (genvar gi = 0; gi < SLAVES; gi++) begin : g_slave
    assign sel_oh[gi]        = route_active && (sel_q == SLAVEID'(gi));
    assign bus.s_control[gi] = sel_oh[gi] ? m_control_g : LINE_IDLE;
    assign bus.s_wD[gi]      = sel_oh[gi] ? m_wd_g      : LINE_IDLE;
    assign bus.s_valid[gi]   = sel_oh[gi] ? m_valid_g   : LINE_IDLE;
    assign bus.s_last[gi]    = sel_oh[gi] ? m_last_g    : LINE_IDLE;
  end

  assign bus.m_rD    = route_active ? (grant_q & {MASTERS{s_rd_g}})    : {MASTERS{LINE_IDLE}};
  assign bus.m_ready = route_active ? (grant_q & {MASTERS{s_ready_g}}) : {MASTERS{LINE_IDLE}};

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed self-checking bench for serial_bus_arbiter (MASTERS=2, SLAVES=3).
// With ARB_TIMEOUT_EN defined the bench runs the TIMEOUT=16 forced-release case.
module tb_serial_bus_arbiter;
  localparam int MASTERS = 2;
  localparam int SLAVES  = 3;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  serial_bus_arbiter_if #(.MASTERS(MASTERS), .SLAVES(SLAVES)) bus ();

  serial_bus_arbiter #(
    .MASTERS (MASTERS),
    .SLAVES  (SLAVES)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge; outputs are sampled and inputs changed there.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req       = '0;
    bus.req_slave = '0;
    bus.done      = '0;
    bus.m_control = '0;
    bus.m_wD      = '0;
    bus.m_valid   = '0;
    bus.m_last    = '0;
    bus.s_rD      = '0;
    bus.s_ready   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [3:0] pat;
  logic [1:0] fair_exp [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    pat = 4'b0111;
    fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

    // Reset holds everything at zero even with requests pending.
    resetn = 1'b0;
    clear_inputs();
    bus.req = 2'b11;
    bus.req_slave = {2'd1, 2'd0};
    step(); step();
    check("rst_grant", bus.grant, 2'b00);
    check("rst_err", bus.err, 2'b00);
    check("rst_s_control", bus.s_control, 3'b000);
    check("rst_m_ready", bus.m_ready, 2'b00);
    bus.req = 2'b00;
    resetn = 1'b1;
    step(); step();
    check("idle_grant", bus.grant, 2'b00);
    check("idle_err", bus.err, 2'b00);

    // Single request from master 0 to slave 2.
    bus.req_slave = {2'd0, 2'd2};
    bus.req       = 2'b01;
    bus.s_ready   = 3'b100;
    bus.s_rD      = 3'b100;
    bus.m_control = 2'b10;
    step();
    check("single_grant", bus.grant, 2'b01);
    for (int i = 0; i < 4; i++) begin
      bus.m_control[0] = pat[i];
      #1;
      check("single_s_control", bus.s_control, {pat[i], 2'b00});
      check("single_m_ready", bus.m_ready, 2'b01);
      step();
    end
    check("single_m_rD", bus.m_rD, 2'b01);
    bus.m_wD = 2'b01; bus.m_valid = 2'b01; bus.m_last = 2'b01;
    #1;
    check("single_s_wD", bus.s_wD, 3'b100);
    check("single_s_valid", bus.s_valid, 3'b100);
    check("single_s_last", bus.s_last, 3'b100);
    bus.s_ready = 3'b000;
    #1;
    check("single_m_ready_low", bus.m_ready, 2'b00);
    // Target changes during BUSY must be ignored.
    bus.req_slave = {2'd0, 2'd0};
    bus.m_control = 2'b01;
    step();
    check("busy_reslave", bus.s_control, 3'b100);
    bus.done = 2'b01;
    bus.req  = 2'b00;
    step();
    bus.done = 2'b00;
    check("single_release_grant", bus.grant, 2'b00);
    check("single_release_route", bus.s_control, 3'b000);
    step();
    check("single_idle_grant", bus.grant, 2'b00);
    clear_inputs();

    // Contention from reset: master 0 first, master 1 after a one-cycle gap.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    bus.req       = 2'b11;
    bus.req_slave = {2'd1, 2'd0};
    step();
    check("cont_grant0", bus.grant, 2'b01);
    bus.done = 2'b10;
    step();
    bus.done = 2'b00;
    check("cont_ignore_done", bus.grant, 2'b01);
    repeat (7) step();
    bus.done = 2'b01;
    bus.req  = 2'b10;
    step();
    bus.done = 2'b00;
    check("cont_gap", bus.grant, 2'b00);
    step();
    check("cont_grant1", bus.grant, 2'b10);
    bus.m_control = 2'b10;
    #1;
    check("cont_route1", bus.s_control, 3'b010);

    // Fairness: both requesting, each grantee finishes at once.
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bus.done = (i % 2 == 0) ? 2'b10 : 2'b01;
      step();
      bus.done = 2'b00;
      check("fair_gap", bus.grant, 2'b00);
      step();
      check("fair_grant", bus.grant, {30'd0, fair_exp[i]});
    end
    bus.req  = 2'b00;
    bus.done = 2'b10;
    step();
    bus.done = 2'b00;
    step();
    clear_inputs();

    // Invalid slave index from master 1.
    bus.req_slave = {2'd3, 2'd0};
    bus.req       = 2'b10;
    step();
    check("inv_err", bus.err, 2'b10);
    check("inv_grant", bus.grant, 2'b00);
    bus.req = 2'b00;
    step();
    check("inv_err_clear", bus.err, 2'b00);
    check("inv_grant_idle", bus.grant, 2'b00);

    // Invalid master 0 rejected, then valid master 1 granted.
    bus.req_slave = {2'd1, 2'd3};
    bus.req       = 2'b11;
    step();
    check("inv2_err", bus.err, 2'b01);
    check("inv2_grant", bus.grant, 2'b00);
    step();
    check("inv2_err_clear", bus.err, 2'b00);
    check("inv2_grant1", bus.grant, 2'b10);
    bus.req = 2'b00;
    step();
    check("inv2_release", bus.grant, 2'b00);
    step();

    // Abort: master 0 drops req during BUSY.
    bus.req_slave = {2'd1, 2'd1};
    bus.req       = 2'b01;
    step();
    check("abort_grant", bus.grant, 2'b01);
    repeat (4) step();
    check("abort_hold", bus.grant, 2'b01);
    bus.req = 2'b00;
    step();
    check("abort_release", bus.grant, 2'b00);
    step();
    check("abort_idle", bus.grant, 2'b00);

    // Asynchronous reset mid-transaction clears outputs and the pointer.
    bus.req       = 2'b01;
    bus.m_control = 2'b01;
    step();
    check("areset_pre_route", bus.s_control, 3'b010);
    #2 resetn = 1'b0;
    #1;
    check("areset_grant", bus.grant, 2'b00);
    check("areset_route", bus.s_control, 3'b000);
    step();
    resetn  = 1'b1;
    bus.req = 2'b11;
    step();
    check("areset_ptr", bus.grant, 2'b01);
    bus.req = 2'b00;
    step(); step();
    clear_inputs();

`ifdef ARB_TIMEOUT_EN
    // Forced release after 16 busy cycles without done.
    bus.req_slave = {2'd1, 2'd0};
    bus.req       = 2'b01;
    step();
    for (int i = 0; i < 16; i++) begin
      check("tout_hold", bus.grant, 2'b01);
      check("tout_quiet", bus.timeout_err, 2'b00);
      step();
    end
    check("tout_grant", bus.grant, 2'b00);
    check("tout_err", bus.timeout_err, 2'b01);
    bus.req = 2'b00;
    step();
    check("tout_err_clear", bus.timeout_err, 2'b00);
    step();
`else
    // Without the timeout, BUSY persists until done or req drop.
    bus.req_slave = {2'd1, 2'd0};
    bus.req       = 2'b01;
    step();
    repeat (20) step();
    check("no_tout_hold", bus.grant, 2'b01);
    bus.req = 2'b00;
    step();
    check("no_tout_release", bus.grant, 2'b00);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
